// File: rtl/tg_axi_pkg.sv
// Shared definitions for the TG AXI4-Lite register-file target: response codes,
// channel FSM states and the address-to-register-index mapping.
package tg_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WWait,
    WResp
  } w_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RResp
  } r_state_e;

  // Word index relative to the base address; the caller range-checks the full result.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned lsb);
    return (addr - base) >> lsb;
  endfunction

endpackage

// File: rtl/tg_axi_regfile.sv
// Register array with one byte-strobed synchronous write port and one
// asynchronous read port; cleared by the asynchronous reset.
module tg_axi_regfile #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 16,
  localparam int unsigned StrbW         = AXI_DATA_WIDTH / 8,
  localparam int unsigned IdxW          = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [IdxW-1:0]           widx,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  input  logic [StrbW-1:0]          wstrb,
  input  logic [IdxW-1:0]           ridx,
  output logic [AXI_DATA_WIDTH-1:0] rdata
);

  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wstrb[b]) begin
          regs_q[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Combinational read sees the pre-write value when a write commits in the same cycle.
  assign rdata = regs_q[ridx];

endmodule

// File: rtl/tg_axi_slave.sv
// AXI4-Lite register-file target: independent write (AW/W/B) and read (AR/R)
// FSMs, one outstanding transaction per direction, optional response wait states.
module tg_axi_slave
  import tg_axi_pkg::*;
#(
  parameter int unsigned     AXI_ADDR_WIDTH = 32,
  parameter int unsigned     AXI_DATA_WIDTH = 32,
  parameter int unsigned     NUM_REGS       = 16,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter int unsigned     WAIT_CYCLES    = 0
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int unsigned StrbW    = AXI_DATA_WIDTH / 8;
  localparam int unsigned AddrLsb  = $clog2(StrbW);
  localparam int unsigned IdxW     = $clog2(NUM_REGS);
  localparam logic [7:0]  WaitInit = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  // ---------------------------------------------------------------- write side
  w_state_e                  w_state_q, w_state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]          wstrb_q, wstrb_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [7:0]                wcnt_q, wcnt_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;

  logic                      aw_hs, w_hs, commit;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_eff;
  logic [AXI_DATA_WIDTH-1:0] w_data_eff;
  logic [StrbW-1:0]          w_strb_eff;
  logic [63:0]               w_idx_full;
  logic                      w_in_range;

  assign aw_hs = awready_q && s_axi_awvalid;
  assign w_hs  = wready_q && s_axi_wvalid;

  // Commit may use a beat arriving this cycle, so mux live inputs over captured ones.
  assign aw_addr_eff = aw_done_q ? awaddr_q : s_axi_awaddr;
  assign w_data_eff  = w_done_q ? wdata_q : s_axi_wdata;
  assign w_strb_eff  = w_done_q ? wstrb_q : s_axi_wstrb;

  assign w_idx_full = addr_to_index(64'(aw_addr_eff), BASE_ADDR, AddrLsb);
  assign w_in_range = (64'(aw_addr_eff) >= BASE_ADDR) && (w_idx_full < 64'(NUM_REGS));

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wcnt_d    = wcnt_q;
    commit    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          commit    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
          if (WAIT_CYCLES > 0) begin
            w_state_d = WWait;
            wcnt_d    = WaitInit;
          end else begin
            w_state_d = WResp;
          end
        end
      end
      WWait: begin
        if (wcnt_q == 8'd0) begin
          w_state_d = WResp;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      WResp: begin
        if (s_axi_bready) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle) && !aw_done_d;
    wready_d  = (w_state_d == WIdle) && !w_done_d;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= WIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      wcnt_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      wcnt_q    <= wcnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = (w_state_q == WResp);
  assign s_axi_bresp   = bresp_q;

  // ----------------------------------------------------------------- read side
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [7:0]                rcnt_q, rcnt_d;
  logic                      arready_q, arready_d;

  logic                      ar_hs;
  logic [63:0]               r_idx_full;
  logic                      r_in_range;
  logic [AXI_DATA_WIDTH-1:0] rf_rdata;

  assign ar_hs      = arready_q && s_axi_arvalid;
  assign r_idx_full = addr_to_index(64'(s_axi_araddr), BASE_ADDR, AddrLsb);
  assign r_in_range = (64'(s_axi_araddr) >= BASE_ADDR) && (r_idx_full < 64'(NUM_REGS));

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rcnt_d    = rcnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          rdata_d = r_in_range ? rf_rdata : '0;
          rresp_d = r_in_range ? RESP_OKAY : RESP_SLVERR;
          if (WAIT_CYCLES > 0) begin
            r_state_d = RWait;
            rcnt_d    = WaitInit;
          end else begin
            r_state_d = RResp;
          end
        end
      end
      RWait: begin
        if (rcnt_q == 8'd0) begin
          r_state_d = RResp;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      RResp: begin
        if (s_axi_rready) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
    arready_d = (r_state_d == RIdle);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_q <= RIdle;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = (r_state_q == RResp);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  // ------------------------------------------------------------- register file
  tg_axi_regfile #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .NUM_REGS       (NUM_REGS)
  ) u_regfile (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .we    (commit && w_in_range),
    .widx  (w_idx_full[IdxW-1:0]),
    .wdata (w_data_eff),
    .wstrb (w_strb_eff),
    .ridx  (r_idx_full[IdxW-1:0]),
    .rdata (rf_rdata)
  );

endmodule

// File: tb/tb_tg_axi_slave.sv
// Directed bench for tg_axi_slave: one instance with no wait states and one with
// four, exercising strobes, ordering, range errors, read/write collision and reset.
module tb_tg_axi_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;

  logic [31:0] awaddr4, wdata4, araddr4, rdata4;
  logic [3:0]  wstrb4;
  logic [1:0]  bresp4, rresp4;
  logic awvalid4, awready4, wvalid4, wready4, bvalid4, bready4;
  logic arvalid4, arready4, rvalid4, rready4;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [16];

  tg_axi_slave #(
    .AXI_ADDR_WIDTH (32), .AXI_DATA_WIDTH (32), .NUM_REGS (16), .BASE_ADDR (0),
    .WAIT_CYCLES (0)
  ) u_dut (
    .s_axi_aclk (clk), .s_axi_aresetn (rst_n),
    .s_axi_awaddr (awaddr), .s_axi_awvalid (awvalid), .s_axi_awready (awready),
    .s_axi_wdata (wdata), .s_axi_wstrb (wstrb), .s_axi_wvalid (wvalid),
    .s_axi_wready (wready), .s_axi_bresp (bresp), .s_axi_bvalid (bvalid),
    .s_axi_bready (bready), .s_axi_araddr (araddr), .s_axi_arvalid (arvalid),
    .s_axi_arready (arready), .s_axi_rdata (rdata), .s_axi_rresp (rresp),
    .s_axi_rvalid (rvalid), .s_axi_rready (rready)
  );

  tg_axi_slave #(
    .AXI_ADDR_WIDTH (32), .AXI_DATA_WIDTH (32), .NUM_REGS (16), .BASE_ADDR (0),
    .WAIT_CYCLES (4)
  ) u_dut4 (
    .s_axi_aclk (clk), .s_axi_aresetn (rst_n),
    .s_axi_awaddr (awaddr4), .s_axi_awvalid (awvalid4), .s_axi_awready (awready4),
    .s_axi_wdata (wdata4), .s_axi_wstrb (wstrb4), .s_axi_wvalid (wvalid4),
    .s_axi_wready (wready4), .s_axi_bresp (bresp4), .s_axi_bvalid (bvalid4),
    .s_axi_bready (bready4), .s_axi_araddr (araddr4), .s_axi_arvalid (arvalid4),
    .s_axi_arready (arready4), .s_axi_rdata (rdata4), .s_axi_rresp (rresp4),
    .s_axi_rvalid (rvalid4), .s_axi_rready (rready4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W are raised after independent delays; bready is held high.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output int lat);
    bit aw_pend, w_pend, aw_hs, w_hs;
    int cyc;
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
    aw_pend = 1; w_pend = 1; cyc = 0;
    while ((aw_pend || w_pend) && cyc < 40) begin
      if (aw_pend && cyc >= aw_dly) awvalid = 1'b1;
      if (w_pend && cyc >= w_dly) wvalid = 1'b1;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_pend = 0; end
      if (w_hs) begin wvalid = 1'b0; w_pend = 0; end
      cyc++;
    end
    if (aw_pend || w_pend) check("wr_handshake_timeout", 64'(aw_pend || w_pend), 64'd0);
    lat = 1;
    while (!bvalid && lat < 40) begin tick(); lat++; end
    if (!bvalid) check("bvalid_timeout", 64'(bvalid), 64'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    bit hs;
    int cyc;
    araddr = addr; arvalid = 1'b1; rready = 1'b1; cyc = 0;
    do begin
      @(negedge clk);
      hs = arready;
      tick();
      cyc++;
    end while (!hs && cyc < 40);
    arvalid = 1'b0;
    if (!hs) check("ar_handshake_timeout", 64'(hs), 64'd1);
    lat = 1;
    while (!rvalid && lat < 40) begin tick(); lat++; end
    if (!rvalid) check("rvalid_timeout", 64'(rvalid), 64'd1);
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    bit          hold_ok, rdy_low;

    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    awaddr4 = '0; wdata4 = '0; wstrb4 = '0; awvalid4 = 0; wvalid4 = 0; bready4 = 0;
    araddr4 = '0; arvalid4 = 0; rready4 = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state and ready timing
    #1 rst_n = 1'b0;
    #1;
    check("rst_readys", {61'd0, awready, wready, arready}, 64'd0);
    check("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("readys_before_edge", {61'd0, awready, wready, arready}, 64'd0);
    tick();
    check("readys_first_edge", {61'd0, awready, wready, arready}, 64'h7);

    // Basic write/read with single-cycle latency
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
    model[4] = 32'hDEADBEEF;
    check("wr10_bresp", 64'(resp), 64'd0);
    check("wr10_latency", 64'(lat), 64'd1);
    do_read(32'h10, data, resp, lat);
    check("rd10_data", 64'(data), 64'hDEADBEEF);
    check("rd10_rresp", 64'(resp), 64'd0);
    check("rd10_latency", 64'(lat), 64'd1);

    // W three cycles ahead of AW, then a partial-strobe update
    do_write(32'h4, 32'h11223344, 4'hF, 3, 0, resp, lat);
    check("wr4_w_first_bresp", 64'(resp), 64'd0);
    do_write(32'h4, 32'hAABBCCDD, 4'h5, 0, 0, resp, lat);
    model[1] = 32'h11BB33DD;
    check("wr4_strb5_bresp", 64'(resp), 64'd0);
    do_read(32'h4, data, resp, lat);
    check("rd4_merged", 64'(data), 64'h11BB33DD);

    // All-zero strobe leaves the register alone
    do_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, resp, lat);
    check("wr10_strb0_bresp", 64'(resp), 64'd0);
    do_read(32'h13, data, resp, lat);
    check("rd13_offset_ignored", 64'(data), 64'hDEADBEEF);

    // Out of range
    do_write(32'h40, 32'h12345678, 4'hF, 0, 0, resp, lat);
    check("wr40_bresp", 64'(resp), 64'd2);
    do_read(32'h40, data, resp, lat);
    check("rd40_rresp", 64'(resp), 64'd2);
    check("rd40_rdata", 64'(data), 64'd0);
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), data, resp, lat);
      check($sformatf("reg%0d_unchanged", i), 64'(data), 64'(model[i]));
    end

    // Write commit and read capture on the same register in the same cycle
    do_write(32'h8, 32'h1, 4'hF, 0, 0, resp, lat);
    awaddr = 32'h8; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h8;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    @(negedge clk);
    check("coll_readys", {61'd0, awready, wready, arready}, 64'h7);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("coll_valids", {62'd0, bvalid, rvalid}, 64'h3);
    check("coll_rdata_old", 64'(rdata), 64'h1);
    check("coll_bresp", 64'(bresp), 64'd0);
    bready = 1; rready = 1;
    tick();
    check("coll_valids_cleared", {62'd0, bvalid, rvalid}, 64'd0);
    bready = 0; rready = 0;
    model[2] = 32'h55;
    do_read(32'h8, data, resp, lat);
    check("coll_followup_rdata", 64'(data), 64'h55);

    // Four wait states with bready withheld
    awaddr4 = 32'hC; wdata4 = 32'hCAFEF00D; wstrb4 = 4'hF; awvalid4 = 1; wvalid4 = 1;
    @(negedge clk);
    check("w4_readys", {62'd0, awready4, wready4}, 64'h3);
    tick();
    awvalid4 = 0; wvalid4 = 0;
    rdy_low = !(awready4 || wready4);
    lat = 1;
    while (!bvalid4 && lat < 20) begin
      tick();
      lat++;
      if (awready4 || wready4) rdy_low = 0;
    end
    check("w4_bvalid_latency", 64'(lat), 64'd5);
    hold_ok = bvalid4;
    repeat (10) begin
      tick();
      if (!bvalid4 || bresp4 !== 2'b00) hold_ok = 0;
      if (awready4 || wready4) rdy_low = 0;
    end
    check("w4_bvalid_held", 64'(hold_ok), 64'd1);
    check("w4_readys_low", 64'(rdy_low), 64'd1);
    bready4 = 1;
    tick();
    bready4 = 0;
    check("w4_bvalid_dropped", 64'(bvalid4), 64'd0);
    check("w4_awready_back", 64'(awready4), 64'd1);

    // Asynchronous reset while a write response is pending
    awaddr = 32'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    tick();
    awvalid = 0; wvalid = 0;
    check("pre_reset_bvalid", 64'(bvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bvalid", 64'(bvalid), 64'd0);
    check("async_rst_readys", {61'd0, awready, wready, arready}, 64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_readys", {61'd0, awready, wready, arready}, 64'h7);
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int i = 0; i < 5; i++) begin
      do_read(32'(i * 4), data, resp, lat);
      check($sformatf("post_rst_reg%0d", i), 64'(data), 64'(model[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
